tkr_dr_sync_tx: RTL

//  Clocked transmitter for a w-bit dual-rail 4-phase push channel (r0/r1 out, a in).

---
 rtl/tkr_hs_defs.sv | 19 +
 rtl/tkr_sync_bit.sv | 23 ++
 rtl/tkr_dr_sync_tx.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/tkr_hs_defs.sv
// Shared handshake state codes for the dual-rail transmitter and its monitors.
// Also holds the width helper for the wait-phase timeout counter.
package tkr_hs_defs;

  typedef enum logic [1:0] {
    TKR_HS_RESET  = 2'd0,
    TKR_HS_SPACER = 2'd1,
    TKR_HS_R      = 2'd2,
    TKR_HS_A      = 2'd3
  } tkr_hs_state_e;

  // The timeout counter is at least 8 bits wide and wide enough to reach the limit.
  function automatic int unsigned tmo_width(input int unsigned limit);
    int unsigned wd;
    wd = $clog2(limit + 1);
    return (wd < 8) ? 8 : wd;
  endfunction

endpackage

// File: rtl/tkr_sync_bit.sv
// Multi-flop synchroniser for a single asynchronous bit, cleared by reset.
module tkr_sync_bit #(
  parameter int unsigned stages = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [stages-1:0] sr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr <= '0;
    end else begin
      sr <= {sr[stages-2:0], d};
    end
  end

  assign q = sr[stages-1];

endmodule

// File: rtl/tkr_dr_sync_tx.sv
// Clocked transmitter: valid/ready words in, dual-rail 4-phase push channel out.
// A small FIFO decouples the sync port from the ack-paced handshake FSM.
module tkr_dr_sync_tx
  import tkr_hs_defs::*;
#(
  parameter int unsigned w           = 8,
  parameter int unsigned depth       = 2,
  parameter int unsigned sync_stages = 2,
  parameter int unsigned timeout     = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [w-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [w-1:0] r0,
  output logic [w-1:0] r1,
  input  logic         a,
  output logic         busy,
  output logic [15:0]  sent_count,
  output logic         timeout_err
);

  localparam int unsigned aw = $clog2(depth);
  localparam int unsigned cw = tmo_width(timeout);
  localparam logic [cw-1:0] tmo_lim = cw'(timeout);
  localparam logic [aw:0]   ptr_one = {{aw{1'b0}}, 1'b1};
  localparam logic [cw-1:0] tmo_one = {{(cw-1){1'b0}}, 1'b1};

  logic a_s;

  tkr_sync_bit #(
    .stages(sync_stages)
  ) u_ack_sync (
    .clk  (clk),
    .reset(reset),
    .d    (a),
    .q    (a_s)
  );

  // FIFO: extra pointer MSB distinguishes full from empty.
  logic [w-1:0] mem [depth];
  logic [aw:0]  wr_ptr, rd_ptr;
  logic         full, empty, push, pop, ready_en;
  logic [w-1:0] head;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[aw] != rd_ptr[aw]) && (wr_ptr[aw-1:0] == rd_ptr[aw-1:0]);
  assign in_ready = ready_en & ~full;
  assign push     = in_valid & in_ready;
  assign head     = mem[rd_ptr[aw-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[aw-1:0]] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + ptr_one;
      if (pop)  rd_ptr <= rd_ptr + ptr_one;
    end
  end

  tkr_hs_state_e state_q, state_d;
  logic [w-1:0]  r0_q, r0_d, r1_q, r1_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [cw-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= TKR_HS_RESET;
      r0_q    <= '0;
      r1_q    <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r0_q    <= r0_d;
      r1_q    <= r1_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    r0_d    = r0_q;
    r1_d    = r1_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    unique case (state_q)
      TKR_HS_RESET: begin
        r0_d = '0;
        r1_d = '0;
        if (!a_s) state_d = TKR_HS_SPACER;
      end
      TKR_HS_SPACER: begin
        if (!empty && !a_s) begin
          pop     = 1'b1;
          r1_d    = head;
          r0_d    = ~head;
          state_d = TKR_HS_R;
        end
      end
      TKR_HS_R: begin
        if (a_s) begin
          r0_d    = '0;
          r1_d    = '0;
          state_d = TKR_HS_A;
        end
      end
      TKR_HS_A: begin
        if (!a_s) begin
          cnt_d   = cnt_q + 16'd1;
          state_d = TKR_HS_SPACER;
        end
      end
      default: state_d = TKR_HS_RESET;
    endcase

    // Wait-phase timer: restarts on any transition, saturates at the limit.
    tmo_d = tmo_q;
    err_d = err_q;
    if (state_d != state_q) begin
      tmo_d = '0;
    end else if (state_q == TKR_HS_R || state_q == TKR_HS_A) begin
      if (tmo_q != tmo_lim) tmo_d = tmo_q + tmo_one;
      if (tmo_d == tmo_lim) err_d = 1'b1;
    end
  end

  assign r0          = r0_q;
  assign r1          = r1_q;
  assign sent_count  = cnt_q;
  assign timeout_err = err_q;
  assign busy        = ~empty | (state_q == TKR_HS_R) | (state_q == TKR_HS_A);

endmodule
